// File: rtl/eye_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eye_pkg
//  Description : Shared types for the eye search scheduler: ROI and result
//                records plus the scheduler state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package eye_pkg;

    // Width of each ROI field; wide enough for any supported frame size.
    localparam int c_ROI_W  = 16;
    // Width of result fields in the generic result record.
    localparam int c_OPEN_W = 32;
    localparam int c_CNT_W  = 16;

    typedef struct packed {
        logic [c_ROI_W-1:0] start_row;
        logic [c_ROI_W-1:0] end_row;
        logic [c_ROI_W-1:0] start_col;
        logic [c_ROI_W-1:0] end_col;
    } roi_t;

    typedef struct packed {
        logic [c_OPEN_W-1:0] openness;
        logic [c_CNT_W-1:0]  sclera;
        logic [c_CNT_W-1:0]  pupil;
    } eye_result_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH_L = 3'd1,
        WAIT_L   = 3'd2,
        LAUNCH_R = 3'd3,
        WAIT_R   = 3'd4,
        PUBLISH  = 3'd5
    } sched_state_t;

endpackage : eye_pkg
`default_nettype wire

// File: rtl/eye_search_scheduler_roi_check.sv
`default_nettype none
// ============================================================================
//  Module      : roi_check
//  Description : Combinational ROI sanity check. Flags an ROI whose start lies
//                beyond its end or whose end lies outside the frame.
//  Revision    : 1.0  initial release
// ============================================================================
module roi_check
    import eye_pkg::*;
#(
    parameter int HEIGHT = 320,
    parameter int WIDTH  = 180
) (
    input  roi_t roi_i,
    output logic bad_o
);

    // Full-width compares so that any upper bits set also count as out of frame.
    assign bad_o = (roi_i.start_row > roi_i.end_row)
                || (roi_i.start_col > roi_i.end_col)
                || (32'(roi_i.end_row) >= 32'(HEIGHT))
                || (32'(roi_i.end_col) >= 32'(WIDTH));

endmodule : roi_check
`default_nettype wire

// File: rtl/eye_search_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : eye_search_scheduler
//  Description : Sequences one shared eye finder over the left and right eye
//                ROIs for every new frame, publishes both eyes' results with a
//                single valid pulse, and queues one frame while busy.
//                Optional per-search watchdog: define SCHEDULER_WATCHDOG_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module eye_search_scheduler
    import eye_pkg::*;
#(
    parameter  int HEIGHT         = 320,
    parameter  int WIDTH          = 180,
    parameter  int FACE_RES       = 65536,
    parameter  int TIMEOUT_CYCLES = 262144,
    localparam int LH             = $clog2(HEIGHT),
    localparam int LW             = $clog2(WIDTH),
    localparam int LR             = $clog2(FACE_RES),
    localparam int EW             = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   frame_done,
    input  logic [2*LH+2*LW-1:0]   left_roi,
    input  logic [2*LH+2*LW-1:0]   right_roi,
    output logic                   finder_start,
    output logic                   finder_rst,
    output logic [LH-1:0]          finder_start_row,
    output logic [LH-1:0]          finder_end_row,
    output logic [LW-1:0]          finder_start_col,
    output logic [LW-1:0]          finder_end_col,
    input  logic                   finder_valid,
    input  logic [LR-1:0]          finder_openness,
    input  logic [EW-1:0]          finder_sclera,
    input  logic [EW-1:0]          finder_pupil,
    output logic [LR-1:0]          left_openness,
    output logic [LR-1:0]          right_openness,
    output logic [EW-1:0]          left_sclera,
    output logic [EW-1:0]          left_pupil,
    output logic [EW-1:0]          right_sclera,
    output logic [EW-1:0]          right_pupil,
    output logic                   results_valid,
    output logic                   busy,
    output logic [3:0]             err_flags
);

    // Packed ROI layout: {start_row, end_row, start_col, end_col}, MSB first.
    roi_t w_left_roi;
    roi_t w_right_roi;

    assign w_left_roi  = '{start_row: c_ROI_W'(left_roi[2*LH+2*LW-1 -: LH]),
                          end_row:   c_ROI_W'(left_roi[LH+2*LW-1 -: LH]),
                          start_col: c_ROI_W'(left_roi[2*LW-1 -: LW]),
                          end_col:   c_ROI_W'(left_roi[LW-1:0])};
    assign w_right_roi = '{start_row: c_ROI_W'(right_roi[2*LH+2*LW-1 -: LH]),
                          end_row:   c_ROI_W'(right_roi[LH+2*LW-1 -: LH]),
                          start_col: c_ROI_W'(right_roi[2*LW-1 -: LW]),
                          end_col:   c_ROI_W'(right_roi[LW-1:0])};

    sched_state_t state_q;
    roi_t         shadow_l_q;
    roi_t         shadow_r_q;
    roi_t         region_q;      // ROI currently presented to the finder
    logic         pending_q;
    logic         finder_start_q;
    logic         results_valid_q;
    logic [3:0]   err_q;
    logic [LR-1:0] left_open_q,  right_open_q;
    logic [EW-1:0] left_scl_q,   right_scl_q;
    logic [EW-1:0] left_pup_q,   right_pup_q;
    logic         w_roi_bad;

    // Validity of the region currently loaded for the active eye.
    roi_check #(
        .HEIGHT (HEIGHT),
        .WIDTH  (WIDTH)
    ) u_roi_check (
        .roi_i (region_q),
        .bad_o (w_roi_bad)
    );

`ifdef SCHEDULER_WATCHDOG_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_WD_W-1:0] wd_cnt_q;
    logic              finder_rst_q;
    logic              w_wd_expired;

    assign w_wd_expired = (wd_cnt_q == c_WD_W'(TIMEOUT_CYCLES - 1));
    assign finder_rst   = finder_rst_q;
`else
    assign finder_rst   = 1'b0;
`endif

    // Scheduler FSM: frame intake, per-eye launch/wait, result capture, publish.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= IDLE;
            shadow_l_q      <= '0;
            shadow_r_q      <= '0;
            region_q        <= '0;
            pending_q       <= 1'b0;
            finder_start_q  <= 1'b0;
            results_valid_q <= 1'b0;
            err_q           <= '0;
            left_open_q     <= '0;
            left_scl_q      <= '0;
            left_pup_q      <= '0;
            right_open_q    <= '0;
            right_scl_q     <= '0;
            right_pup_q     <= '0;
`ifdef SCHEDULER_WATCHDOG_EN
            wd_cnt_q        <= '0;
            finder_rst_q    <= 1'b0;
`endif
        end else begin
            finder_start_q  <= 1'b0;
            results_valid_q <= 1'b0;
`ifdef SCHEDULER_WATCHDOG_EN
            finder_rst_q    <= 1'b0;
`endif
            // One-deep frame queue; extra frames while busy are dropped.
            if (frame_done && (state_q != IDLE)) begin
                pending_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (frame_done || pending_q) begin
                        shadow_l_q <= w_left_roi;
                        shadow_r_q <= w_right_roi;
                        region_q   <= w_left_roi;
                        pending_q  <= 1'b0;
                        state_q    <= LAUNCH_L;
                    end
                end

                LAUNCH_L: begin
                    if (w_roi_bad) begin
                        left_open_q <= '0;
                        left_scl_q  <= '0;
                        left_pup_q  <= '0;
                        err_q[0]    <= 1'b1;
                        region_q    <= shadow_r_q;
                        state_q     <= LAUNCH_R;
                    end else begin
                        finder_start_q <= 1'b1;
`ifdef SCHEDULER_WATCHDOG_EN
                        wd_cnt_q       <= '0;
`endif
                        state_q        <= WAIT_L;
                    end
                end

                WAIT_L: begin
                    if (finder_valid) begin
                        left_open_q <= finder_openness;
                        left_scl_q  <= finder_sclera;
                        left_pup_q  <= finder_pupil;
                        region_q    <= shadow_r_q;
                        state_q     <= LAUNCH_R;
                    end
`ifdef SCHEDULER_WATCHDOG_EN
                    else if (w_wd_expired) begin
                        finder_rst_q <= 1'b1;
                        left_open_q  <= '0;
                        left_scl_q   <= '0;
                        left_pup_q   <= '0;
                        err_q[2]     <= 1'b1;
                        region_q     <= shadow_r_q;
                        state_q      <= LAUNCH_R;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end

                LAUNCH_R: begin
                    if (w_roi_bad) begin
                        right_open_q    <= '0;
                        right_scl_q     <= '0;
                        right_pup_q     <= '0;
                        err_q[1]        <= 1'b1;
                        results_valid_q <= 1'b1;
                        state_q         <= PUBLISH;
                    end else begin
                        finder_start_q <= 1'b1;
`ifdef SCHEDULER_WATCHDOG_EN
                        wd_cnt_q       <= '0;
`endif
                        state_q        <= WAIT_R;
                    end
                end

                WAIT_R: begin
                    if (finder_valid) begin
                        right_open_q    <= finder_openness;
                        right_scl_q     <= finder_sclera;
                        right_pup_q     <= finder_pupil;
                        results_valid_q <= 1'b1;
                        state_q         <= PUBLISH;
                    end
`ifdef SCHEDULER_WATCHDOG_EN
                    else if (w_wd_expired) begin
                        finder_rst_q    <= 1'b1;
                        right_open_q    <= '0;
                        right_scl_q     <= '0;
                        right_pup_q     <= '0;
                        err_q[3]        <= 1'b1;
                        results_valid_q <= 1'b1;
                        state_q         <= PUBLISH;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end

                PUBLISH: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy             = (state_q != IDLE);
    assign finder_start     = finder_start_q;
    assign results_valid    = results_valid_q;
    assign err_flags        = err_q;
    assign finder_start_row = region_q.start_row[LH-1:0];
    assign finder_end_row   = region_q.end_row[LH-1:0];
    assign finder_start_col = region_q.start_col[LW-1:0];
    assign finder_end_col   = region_q.end_col[LW-1:0];
    assign left_openness    = left_open_q;
    assign left_sclera      = left_scl_q;
    assign left_pupil       = left_pup_q;
    assign right_openness   = right_open_q;
    assign right_sclera     = right_scl_q;
    assign right_pupil      = right_pup_q;

endmodule : eye_search_scheduler
`default_nettype wire
